// File: rtl/servo_pkg.sv
// -----------------------------------------------------------------------------
// servo_pkg
// Constants shared by the servo PWM generator and decoder: the nominal frame
// period, the three supported positions (high time in us) and the duty codes
// they map to. Also holds the decoder FSM state type and a tolerance helper.
// -----------------------------------------------------------------------------
package servo_pkg;

  localparam int unsigned SERVO_PERIOD_US = 20000;

  localparam int unsigned POS_MINUS90_US = 500;
  localparam int unsigned POS_CENTRE_US  = 1500;
  localparam int unsigned POS_PLUS90_US  = 2500;

  localparam logic [7:0] DUTY_MINUS90 = 8'd0;
  localparam logic [7:0] DUTY_CENTRE  = 8'd15;
  localparam logic [7:0] DUTY_PLUS90  = 8'd255;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } dec_state_t;

  // |val - nom| <= tol, evaluated on 17 bits so neither subtraction underflows.
  function automatic logic within_tol(input logic [15:0] val,
                                      input logic [15:0] nom,
                                      input logic [15:0] tol);
    logic [16:0] diff;
    if ({1'b0, val} >= {1'b0, nom}) begin
      diff = {1'b0, val} - {1'b0, nom};
    end else begin
      diff = {1'b0, nom} - {1'b0, val};
    end
    return (diff <= {1'b0, tol});
  endfunction

endpackage

// File: rtl/us_tick_gen.sv
// -----------------------------------------------------------------------------
// us_tick_gen
// Prescaler producing a one-cycle tick every CLKS_PER_TICK clocks. The counter
// runs 0..CLKS_PER_TICK-1 and the tick is the terminal count. A synchronous
// restart puts the counter back to 0 so the tick phase can be aligned to an
// external event.
//   i_clk      clock
//   i_rst      synchronous active-high reset
//   i_restart  synchronous restart of the count (phase alignment)
//   o_tick     high for one cycle at the terminal count
// -----------------------------------------------------------------------------
module us_tick_gen #(
  parameter int unsigned CLKS_PER_TICK = 50
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_restart,
  output logic o_tick
);

  localparam int unsigned CW = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
  localparam logic [CW-1:0] TERM = CW'(CLKS_PER_TICK - 1);

  logic [CW-1:0] r_cnt;
  logic          w_term;

  assign w_term = (r_cnt == TERM);
  assign o_tick = w_term;

  // Prescale counter with restart and wrap at the terminal count.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_restart) begin
      r_cnt <= '0;
    end else if (w_term) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/servo_pwm_decoder.sv
// -----------------------------------------------------------------------------
// servo_pwm_decoder
// Measures a hobby-servo PWM input (high time and period in us) and maps it
// to the duty-code space of the servo generator (0 / 15 / 255).
//   d_in_clk       clock
//   d_reset        synchronous active-high reset
//   d_enable       low: FSM idle, counters cleared, outputs hold
//   d_pwm_in       asynchronous PWM input
//   d_pulse_us     last measured high time (us)
//   d_period_us    last measured period (us)
//   d_duty_cycle   last valid decoded code
//   d_valid        one-cycle strobe: a cycle was decoded
//   d_error        one-cycle strobe: cycle rejected or timeout
//   d_signal_lost  set on timeout, cleared by the next d_valid
// -----------------------------------------------------------------------------
module servo_pwm_decoder
  import servo_pkg::*;
#(
  parameter int unsigned CLK_HZ        = 50_000_000,
  parameter int unsigned TOL_US        = 100,
  parameter int unsigned PERIOD_TOL_US = 1000,
  parameter int unsigned TIMEOUT_US    = 25000
) (
  input  logic        d_in_clk,
  input  logic        d_reset,
  input  logic        d_enable,
  input  logic        d_pwm_in,
  output logic [15:0] d_pulse_us,
  output logic [15:0] d_period_us,
  output logic [7:0]  d_duty_cycle,
  output logic        d_valid,
  output logic        d_error,
  output logic        d_signal_lost
);

  localparam int unsigned CLKS_PER_US = CLK_HZ / 1_000_000;

  localparam logic [15:0] TOL16      = 16'(TOL_US);
  localparam logic [15:0] PTOL16     = 16'(PERIOD_TOL_US);
  localparam logic [15:0] TIMEOUT16  = 16'(TIMEOUT_US);
  localparam logic [15:0] PERIOD16   = 16'(SERVO_PERIOD_US);
  localparam logic [15:0] NOM_M90    = 16'(POS_MINUS90_US);
  localparam logic [15:0] NOM_CTR    = 16'(POS_CENTRE_US);
  localparam logic [15:0] NOM_P90    = 16'(POS_PLUS90_US);

  // ---------------------------------------------------------------------------
  // Input synchronizer and edge detection
  // ---------------------------------------------------------------------------
  logic       r_sync1;
  logic       r_sync2;
  logic       r_pwm_d;
  logic [1:0] r_blank;
  logic       w_rise;
  logic       w_fall;

  // Two-flop synchronizer plus delayed copy. After reset the synchronizer is
  // empty; r_blank suppresses edges until it has refilled, so a line that is
  // already high when reset releases is not mistaken for a fresh rising edge.
  always_ff @(posedge d_in_clk) begin
    if (d_reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_pwm_d <= 1'b0;
      r_blank <= 2'd3;
    end else begin
      r_sync1 <= d_pwm_in;
      r_sync2 <= r_sync1;
      r_pwm_d <= r_sync2;
      if (r_blank != 2'd0) begin
        r_blank <= r_blank - 2'd1;
      end else begin
        r_blank <= r_blank;
      end
    end
  end

  assign w_rise = r_sync2 & ~r_pwm_d & (r_blank == 2'd0);
  assign w_fall = ~r_sync2 & r_pwm_d & (r_blank == 2'd0);

  // ---------------------------------------------------------------------------
  // Microsecond timebase and saturating counters
  // ---------------------------------------------------------------------------
  dec_state_t  r_state;
  dec_state_t  w_state_next;
  logic        w_tick;
  logic        w_restart;
  logic        w_clr_cnt;
  logic        w_latch_hi;
  logic        w_eval;
  logic        w_timeout_evt;

  logic [15:0] r_hi_us;
  logic [15:0] r_per_us;
  logic [15:0] r_hi_hold;
  logic [15:0] w_hi_inc;
  logic [15:0] w_per_inc;
  logic        w_timeout;

  us_tick_gen #(
    .CLKS_PER_TICK (CLKS_PER_US)
  ) u_us_tick (
    .i_clk     (d_in_clk),
    .i_rst     (d_reset),
    .i_restart (w_restart),
    .o_tick    (w_tick)
  );

  // Counter values including this cycle's tick: latching and evaluating these
  // instead of the registers makes an edge that lands on a tick count it.
  assign w_hi_inc  = (w_tick && (r_hi_us  != 16'hFFFF)) ? (r_hi_us  + 16'd1) : r_hi_us;
  assign w_per_inc = (w_tick && (r_per_us != 16'hFFFF)) ? (r_per_us + 16'd1) : r_per_us;
  assign w_timeout = (w_per_inc >= TIMEOUT16);

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------

  // State register.
  always_ff @(posedge d_in_clk) begin
    if (d_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state and datapath controls. Timeout has priority over a rise in the
  // same cycle, so that rise is dropped and the next one starts afresh.
  always_comb begin
    w_state_next  = r_state;
    w_clr_cnt     = 1'b0;
    w_latch_hi    = 1'b0;
    w_eval        = 1'b0;
    w_timeout_evt = 1'b0;
    w_restart     = 1'b0;
    if (!d_enable) begin
      w_state_next = ST_IDLE;
      w_clr_cnt    = 1'b1;
      w_restart    = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_rise) begin
            w_state_next = ST_HIGH;
            w_clr_cnt    = 1'b1;
            w_restart    = 1'b1;
          end else begin
            w_state_next = ST_IDLE;
          end
        end
        ST_HIGH: begin
          if (w_timeout) begin
            w_state_next  = ST_IDLE;
            w_timeout_evt = 1'b1;
            w_clr_cnt     = 1'b1;
          end else if (w_fall) begin
            w_state_next = ST_LOW;
            w_latch_hi   = 1'b1;
          end else begin
            w_state_next = ST_HIGH;
          end
        end
        ST_LOW: begin
          if (w_timeout) begin
            w_state_next  = ST_IDLE;
            w_timeout_evt = 1'b1;
            w_clr_cnt     = 1'b1;
          end else if (w_rise) begin
            w_state_next = ST_HIGH;
            w_eval       = 1'b1;
            w_clr_cnt    = 1'b1;
            w_restart    = 1'b1;
          end else begin
            w_state_next = ST_LOW;
          end
        end
        default: begin
          w_state_next = ST_IDLE;
          w_clr_cnt    = 1'b1;
        end
      endcase
    end
  end

  // High-time and period counters, plus the high-time hold register.
  always_ff @(posedge d_in_clk) begin
    if (d_reset) begin
      r_hi_us   <= 16'd0;
      r_per_us  <= 16'd0;
      r_hi_hold <= 16'd0;
    end else begin
      if (w_clr_cnt) begin
        r_hi_us  <= 16'd0;
        r_per_us <= 16'd0;
      end else begin
        case (r_state)
          ST_HIGH: begin
            r_hi_us  <= w_hi_inc;
            r_per_us <= w_per_inc;
          end
          ST_LOW: begin
            r_hi_us  <= r_hi_us;
            r_per_us <= w_per_inc;
          end
          default: begin
            r_hi_us  <= r_hi_us;
            r_per_us <= r_per_us;
          end
        endcase
      end
      if (w_latch_hi) begin
        r_hi_hold <= w_hi_inc;
      end else begin
        r_hi_hold <= r_hi_hold;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Classifier
  // ---------------------------------------------------------------------------
  logic       w_per_ok;
  logic       w_pos_hit;
  logic [7:0] w_code;

  assign w_per_ok = within_tol(w_per_inc, PERIOD16, PTOL16);

  // Map the held high time onto one of the three nominal positions.
  always_comb begin
    w_pos_hit = 1'b0;
    w_code    = DUTY_MINUS90;
    if (within_tol(r_hi_hold, NOM_M90, TOL16)) begin
      w_pos_hit = 1'b1;
      w_code    = DUTY_MINUS90;
    end else if (within_tol(r_hi_hold, NOM_CTR, TOL16)) begin
      w_pos_hit = 1'b1;
      w_code    = DUTY_CENTRE;
    end else if (within_tol(r_hi_hold, NOM_P90, TOL16)) begin
      w_pos_hit = 1'b1;
      w_code    = DUTY_PLUS90;
    end else begin
      w_pos_hit = 1'b0;
      w_code    = DUTY_MINUS90;
    end
  end

  // ---------------------------------------------------------------------------
  // Output registers
  // ---------------------------------------------------------------------------

  // Measurements update on every closed period; the code only on a good one.
  always_ff @(posedge d_in_clk) begin
    if (d_reset) begin
      d_pulse_us    <= 16'd0;
      d_period_us   <= 16'd0;
      d_duty_cycle  <= 8'd0;
      d_valid       <= 1'b0;
      d_error       <= 1'b0;
      d_signal_lost <= 1'b0;
    end else begin
      d_valid <= 1'b0;
      d_error <= 1'b0;
      if (w_eval) begin
        d_pulse_us  <= r_hi_hold;
        d_period_us <= w_per_inc;
        if (w_per_ok && w_pos_hit) begin
          d_duty_cycle  <= w_code;
          d_valid       <= 1'b1;
          d_signal_lost <= 1'b0;
        end else begin
          d_error <= 1'b1;
        end
      end else if (w_timeout_evt) begin
        d_error       <= 1'b1;
        d_signal_lost <= 1'b1;
      end else begin
        d_signal_lost <= d_signal_lost;
      end
    end
  end

endmodule

// File: tb/tb_servo_pwm_decoder.sv
// Bench for servo_pwm_decoder. Runs at 2 clocks per us with shortened period
// tolerance and timeout so a full scenario fits in a small cycle budget. PWM
// edges are placed on whole microseconds so measurements are exact.
module tb_servo_pwm_decoder;

  localparam int unsigned CLK_HZ = 2_000_000;
  localparam int N    = 2;
  localparam int TOL  = 100;
  localparam int PTOL = 17400;   // period accepted from 2600 us upward
  localparam int TMO  = 2700;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        pwm;
  logic [15:0] pulse;
  logic [15:0] period;
  logic [7:0]  duty;
  logic        valid;
  logic        err;
  logic        lost;

  always #5 clk = ~clk;

  servo_pwm_decoder #(
    .CLK_HZ        (CLK_HZ),
    .TOL_US        (TOL),
    .PERIOD_TOL_US (PTOL),
    .TIMEOUT_US    (TMO)
  ) dut (
    .d_in_clk      (clk),
    .d_reset       (rst),
    .d_enable      (en),
    .d_pwm_in      (pwm),
    .d_pulse_us    (pulse),
    .d_period_us   (period),
    .d_duty_cycle  (duty),
    .d_valid       (valid),
    .d_error       (err),
    .d_signal_lost (lost)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_valid  = 0;
  int n_err    = 0;

  // reference model state
  int m_valid = 0, m_err = 0, m_pulse = 0, m_period = 0, m_duty = 0, m_lost = 0;
  bit m_armed = 0;
  int prev_hi = 0, prev_per = 0;

  // count strobes seen on the outputs
  always @(negedge clk) begin
    if (valid === 1'b1) n_valid++;
    if (err === 1'b1)   n_err++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".nvalid"}, n_valid, m_valid);
    check({tag, ".nerror"}, n_err, m_err);
    check({tag, ".pulse"}, {16'd0, pulse}, m_pulse);
    check({tag, ".period"}, {16'd0, period}, m_period);
    check({tag, ".duty"}, {24'd0, duty}, m_duty);
    check({tag, ".lost"}, {31'd0, lost}, m_lost);
  endtask

  task automatic wait_neg(input int k);
    repeat (k) @(negedge clk);
  endtask

  function automatic bit near(input int v, input int nom);
    return (v >= nom - TOL) && (v <= nom + TOL);
  endfunction

  // what a rising edge does, from the behavioural rules
  task automatic model_rise();
    bit per_ok, hit;
    int code;
    if (m_armed && prev_per == TMO) begin
      // timeout lands on the rise itself: timeout wins, rise ignored
      m_err++; m_lost = 1; m_armed = 0;
    end else if (m_armed) begin
      m_pulse  = prev_hi;
      m_period = prev_per;
      per_ok = (prev_per >= 20000 - PTOL) && (prev_per <= 20000 + PTOL);
      hit = 1; code = 0;
      if (near(prev_hi, 500)) code = 0;
      else if (near(prev_hi, 1500)) code = 15;
      else if (near(prev_hi, 2500)) code = 255;
      else hit = 0;
      if (per_ok && hit) begin
        m_duty = code; m_valid++; m_lost = 0;
      end else begin
        m_err++;
      end
    end else begin
      m_armed = 1;
    end
  endtask

  // one PWM frame starting with a rise; optional enable drop or reset mid-high
  task automatic send(input int idx, input int hi, input int per,
                      input int en_drop_at, input int rst_at);
    string tag;
    tag = $sformatf("s%0d", idx);
    pwm = 1'b1;
    model_rise();
    wait_neg(8);
    check_all({tag, ".rise"});
    if (en_drop_at > 0) begin
      wait_neg(en_drop_at - 8);
      en = 1'b0;
      wait_neg(10);
      en = 1'b1;
      m_armed = 0;
      wait_neg(hi * N - en_drop_at - 10);
    end else if (rst_at > 0) begin
      wait_neg(rst_at - 8);
      rst = 1'b1;
      wait_neg(1);
      rst = 1'b0;
      m_pulse = 0; m_period = 0; m_duty = 0; m_lost = 0; m_armed = 0;
      check_all({tag, ".reset"});
      check({tag, ".reset.valid"}, {31'd0, valid}, 0);
      check({tag, ".reset.error"}, {31'd0, err}, 0);
      wait_neg(hi * N - rst_at - 1);
    end else begin
      wait_neg(hi * N - 8);
    end
    pwm = 1'b0;
    if (per > TMO + 20) begin
      wait_neg((TMO - hi) * N - 2);
      check({tag, ".pre_timeout"}, n_err, m_err);
      m_err++; m_lost = 1; m_armed = 0;
      wait_neg(10);
      check_all({tag, ".timeout"});
      wait_neg((per - TMO) * N - 8);
    end else begin
      wait_neg((per - hi) * N);
    end
    prev_hi  = hi;
    prev_per = per;
  endtask

  function automatic int rj();
    return int'($urandom_range(2 * TOL)) - TOL;
  endfunction

  function automatic int rp();
    return 2600 + int'($urandom_range(50));
  endfunction

  initial begin
    rst = 1'b1;
    en  = 1'b1;
    pwm = 1'b0;
    wait_neg(3);
    rst = 1'b0;
    check_all("reset");
    check("reset.valid", {31'd0, valid}, 0);
    check("reset.error", {31'd0, err}, 0);
    wait_neg(5);

    send(0,  1500,             2600, 0, 0);   // first edge
    send(1,  1500 + TOL,       2600, 0, 0);   // boundary high, boundary period
    send(2,  1500 + rj(),      rp(), 0, 0);
    send(3,  500 + rj(),       rp(), 0, 0);
    send(4,  2500 - int'($urandom_range(TOL)), rp(), 0, 0);
    send(5,  1000,             rp(), 0, 0);   // no position match
    send(6,  1500,             2000, 0, 0);   // bad period
    send(7,  1500,             2800, 0, 0);   // timeout in low phase
    send(8,  300,              400,  200, 0); // enable dropped mid-high
    send(9,  1500 + rj(),      rp(), 0, 0);   // first edge again
    send(10, 2500,             TMO,  0, 0);   // closing rise coincides with timeout
    send(11, 300,              400,  0, 0);   // rise ignored
    send(12, 300,              400,  0, 200); // reset mid-high
    send(13, 500 - TOL,        rp(), 0, 0);   // first edge after reset
    send(14, 2500 - int'($urandom_range(TOL)), rp(), 0, 0);

    pwm = 1'b1;
    model_rise();
    wait_neg(8);
    check_all("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
